// File: rtl/exec_unit.sv
// exec_unit: multi-cycle execute stage feeding the register file write port.
// Single-cycle ALU ops (ADD/SUB/AND/OR/XOR/SHL) complete one cycle after start.
// MUL (shift-add) and DIV (restoring) iterate once per bit before write-back.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op, dst    request, opcode and destination, sampled only when idle
//   a, b              operands from register file read ports
//   busy              operation in progress
//   done, wr_en       one-cycle completion / register file write strobe
//   write_reg/data    destination and result, held until next completion
//   zero, carry       result flags, updated with done
//   div_zero          DIV issued with b == 0, updated with done
module exec_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] dst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [REG_AW-1:0] write_reg,
  output logic [WIDTH-1:0]  write_data,
  output logic              zero,
  output logic              carry,
  output logic              div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  // Operation context. For MUL: opa = shifted multiplicand, opb = shifted
  // multiplier, acc = partial product. For DIV: opa = dividend shifting into
  // quotient, opb = divisor (kept intact for the div_zero flag), acc = remainder.
  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              busy_d, done_d, wr_en_d;
  logic [REG_AW-1:0] write_reg_d;
  logic [WIDTH-1:0]  write_data_d;
  logic              zero_d, carry_d, div_zero_d;

  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  result;
  logic              res_carry;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    rem_diff;

  // Final result selection, evaluated from the latched context in WB.
  always_comb begin
    sum       = {1'b0, opa_q} + {1'b0, opb_q};
    result    = '0;
    res_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        result    = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
      end
      OP_SUB: begin
        result    = opa_q - opb_q;
        res_carry = (opa_q < opb_q);
      end
      OP_AND: result = opa_q & opb_q;
      OP_OR:  result = opa_q | opb_q;
      OP_XOR: result = opa_q ^ opb_q;
      OP_SHL: result = opa_q << opb_q[3:0];
      OP_MUL: result = acc_q;
      OP_DIV: result = opa_q;
    endcase
  end

  // Restoring-division trial subtract; a zero divisor always "fits",
  // which naturally yields an all-ones quotient.
  always_comb begin
    rem_sh   = {acc_q, opa_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    busy_d       = busy;
    done_d       = 1'b0;
    wr_en_d      = 1'b0;
    write_reg_d  = write_reg;
    write_data_d = write_data;
    zero_d       = zero;
    carry_d      = carry;
    div_zero_d   = div_zero;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          dst_d  = dst;
          opa_d  = a;
          opb_d  = b;
          acc_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          state_d = (op == OP_MUL || op == OP_DIV) ? S_CALC : S_WB;
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          if (opb_q[0]) begin
            acc_d = acc_q + opa_q;
          end
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          if (!rem_diff[WIDTH]) begin
            acc_d = rem_diff[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        write_data_d = result;
        write_reg_d  = dst_q;
        zero_d       = (result == '0);
        carry_d      = res_carry;
        div_zero_d   = (op_q == OP_DIV) && (opb_q == '0);
        done_d       = 1'b1;
        wr_en_d      = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_en      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      zero       <= 1'b0;
      carry      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      wr_en      <= wr_en_d;
      write_reg  <= write_reg_d;
      write_data <= write_data_d;
      zero       <= zero_d;
      carry      <= carry_d;
      div_zero   <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit with a scoreboard of expected write-backs.
module tb_exec_unit;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] DIV = 3'b111;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  dst;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        zero;
  logic        carry;
  logic        div_zero;

  exec_unit #(.WIDTH(16), .REG_AW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst), .a(a), .b(b),
    .busy(busy), .done(done), .wr_en(wr_en), .write_reg(write_reg),
    .write_data(write_data), .zero(zero), .carry(carry), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  wreg;
    logic [15:0] data;
    logic        z;
    logic        c;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  int wr_cnt = 0;
  int start_cyc = 0;
  int base;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // Drive a request at the current negedge; returns one negedge later.
  task automatic issue(input string tag, input logic [2:0] o, input logic [2:0] d,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ed, input logic ez, input logic ec,
                       input logic edz, input int elat, input bit push);
    exp_t e;
    start = 1'b1; op = o; dst = d; a = x; b = y;
    start_cyc = cyc_cnt;
    if (push) begin
      e.tag = tag; e.wreg = d; e.data = ed; e.z = ez; e.c = ec; e.dz = edz; e.lat = elat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then pop and compare the oldest expectation.
  task automatic wait_done();
    exp_t e;
    int   n;
    bit   busy_bad;
    n = 0;
    busy_bad = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_has_entry", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ":done"},       32'(done),       32'd1);
    chk({e.tag, ":wr_en"},      32'(wr_en),      32'd1);
    chk({e.tag, ":busy_off"},   32'(busy),       32'd0);
    chk({e.tag, ":busy_held"},  32'(busy_bad),   32'd0);
    chk({e.tag, ":latency"},    32'(cyc_cnt - start_cyc - 1), 32'(e.lat));
    chk({e.tag, ":write_reg"},  32'(write_reg),  32'(e.wreg));
    chk({e.tag, ":write_data"}, 32'(write_data), 32'(e.data));
    chk({e.tag, ":zero"},       32'(zero),       32'(e.z));
    chk({e.tag, ":carry"},      32'(carry),      32'(e.c));
    chk({e.tag, ":div_zero"},   32'(div_zero),   32'(e.dz));
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [2:0] d,
                     input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] ed, input logic ez, input logic ec,
                     input logic edz, input int elat);
    issue(tag, o, d, x, y, ed, ez, ec, edz, elat, 1'b1);
    wait_done();
    @(negedge clk);
    chk({tag, ":done_drop"},  32'(done),       32'd0);
    chk({tag, ":wr_en_drop"}, 32'(wr_en),      32'd0);
    chk({tag, ":data_hold"},  32'(write_data), 32'(ed));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; dst = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:wr_en", 32'(wr_en), 0);
    chk("rst:write_reg", 32'(write_reg), 0);
    chk("rst:write_data", 32'(write_data), 0);
    chk("rst:flags", {29'd0, zero, carry, div_zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle ops
    run("add_1_1",      ADD, 3'd3, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 1);
    run("add_wrap",     ADD, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 1);
    run("sub_borrow",   SUB, 3'd4, 16'h0001, 16'h0002, 16'hFFFF, 0, 1, 0, 1);
    run("and",          AND, 3'd5, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 1);
    run("or",           OR,  3'd6, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 1);
    run("xor",          XOR, 3'd7, 16'hFFFF, 16'h00FF, 16'hFF00, 0, 0, 0, 1);
    run("shl_lownib",   SHL, 3'd2, 16'h0001, 16'h0013, 16'h0008, 0, 0, 0, 1);

    // Iterative ops
    run("mul_123x10",   MUL, 3'd1, 16'h0123, 16'h0010, 16'h1230, 0, 0, 0, 17);
    run("mul_ovf",      MUL, 3'd2, 16'h1000, 16'h0010, 16'h0000, 1, 0, 0, 17);
    run("div_100_7",    DIV, 3'd3, 16'h0064, 16'h0007, 16'h000E, 0, 0, 0, 17);
    run("div_by_zero",  DIV, 3'd4, 16'h1234, 16'h0000, 16'hFFFF, 0, 0, 1, 17);
    run("div_small",    DIV, 3'd5, 16'h0005, 16'h0007, 16'h0000, 1, 0, 0, 17);

    // Start while busy is ignored; start in the done cycle is accepted
    base = wr_cnt;
    issue("mul_3x5", MUL, 3'd1, 16'h0003, 16'h0005, 16'h000F, 0, 0, 0, 17, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; op = ADD; dst = 3'd6; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("overlap:no_early_pulse", 32'(wr_cnt - base), 0);
    issue("b2b_add", ADD, 3'd2, 16'h0007, 16'h0008, 16'h000F, 0, 0, 0, 1, 1'b1);
    wait_done();
    chk("overlap:one_mul_pulse", 32'(wr_cnt - base), 1);
    @(negedge clk);
    chk("overlap:two_pulses", 32'(wr_cnt - base), 2);

    // Reset in the middle of a DIV aborts it without a write
    base = wr_cnt;
    issue("div_abort", DIV, 3'd4, 16'h0100, 16'h0002, 16'h0080, 0, 0, 0, 17, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort:busy", 32'(busy), 0);
    chk("abort:done", 32'(done), 0);
    chk("abort:write_data", 32'(write_data), 0);
    repeat (20) @(negedge clk);
    chk("abort:no_pulse", 32'(wr_cnt - base), 0);
    run("add_after_rst", ADD, 3'd5, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 1);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Multi-cycle execute stage directly downstream of the 8x16 register file.
- Consumes the two register read ports (reg1/reg2) as operands a/b and computes one of eight ALU/MUL/DIV operations.
- Drives the register file write port (wr_en, write_reg, write_data) for exactly one cycle per completed operation.
- Single-cycle ops finish in 1 cycle; MUL/DIV are iterative (16 iterations).

Parameters:
- WIDTH, 16, operand/result width; must match register file data width.
- REG_AW, 3, register address width (8 registers).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code, sampled with start.
- dst  in  REG_AW  destination register, sampled with start.
- a  in  WIDTH  operand A (register file reg1), sampled with start.
- b  in  WIDTH  operand B (register file reg2), sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- wr_en  out  1  register file write enable, one-cycle pulse coincident with done.
- write_reg  out  REG_AW  destination register to register file.
- write_data  out  WIDTH  result to register file.
- zero  out  1  result == 0; updated with done, held otherwise.
- carry  out  1  ADD carry-out / SUB borrow; 0 for other ops; updated with done, held.
- div_zero  out  1  DIV with b == 0; updated with done, held.

Behaviour:
- Reset values: busy=0, done=0, wr_en=0, write_reg=0, write_data=0, zero=0, carry=0, div_zero=0, state=IDLE, iteration counter=0.
- Opcodes, unsigned, results truncated to WIDTH:
  - 000 ADD: a+b.
  - 001 SUB: a-b; carry = (a<b).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a << b[3:0].
  - 110 MUL: low WIDTH bits of a*b, shift-add.
  - 111 DIV: quotient a/b, restoring division.
- FSM states: IDLE, CALC, WB.
  - IDLE: on a rising edge with start=1, latch op/dst/a/b and set busy=1. Ops 000-101 go to WB. Ops 110/111 go to CALC with counter=0.
  - CALC: one iteration per cycle; counter increments. After 16 iterations (counter==15 at the edge), go to WB.
  - WB: on the next edge, register write_data/write_reg/flags, set done=1, wr_en=1, busy=0, and go to IDLE.
- Latency, from the start-sampling edge to done high:
  - 1 cycle for ops 000-101.
  - 17 cycles for MUL/DIV.
  - busy is high for exactly those cycles.
- done and wr_en are high for exactly one cycle, then drop to 0. write_data and write_reg hold their value until the next completion.
- The register file commits on the falling edge inside the wr_en cycle, so the written value is readable on a/b in the following cycle.
- Back-to-back: start asserted during the done cycle (state IDLE) is accepted. Maximum throughput is one ADD every 2 cycles.
- start while busy=1 is ignored: no queueing, no effect on the running operation.
- DIV with b==0: the algorithm runs the full 16 iterations and yields quotient 0xFFFF. It writes 0xFFFF, with div_zero=1, zero=0, carry=0.
- MUL overflow is silently truncated; no flag is set.
- rst asserted in any state, including mid-CALC or WB: on that edge return to IDLE and clear all outputs to reset values. The aborted operation produces no wr_en pulse.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then ADD a=0x0001 b=0x0001 dst=3, start for one cycle -> one cycle later done=1, wr_en=1, write_reg=3, write_data=0x0002, zero=0, carry=0; next cycle done=0, wr_en=0.
- ADD 0xFFFF+0x0001 -> write_data=0x0000, zero=1, carry=1; then SUB 0x0001-0x0002 -> 0xFFFF, carry=1, zero=0.
- MUL 0x0123*0x0010 -> busy high 17 cycles, then write_data=0x1230. MUL 0x1000*0x0010 -> 0x0000, zero=1.
- DIV 0x0064/0x0007 -> after 17 cycles write_data=0x000E. DIV 0x1234/0x0000 -> write_data=0xFFFF, div_zero=1.
- Overlapping requests:
  - MUL 0x0003*0x0005 dst=1, then ADD start pulsed at cycle 5 -> ADD ignored; exactly one wr_en pulse, write_reg=1, write_data=0x000F.
  - ADD started in that done cycle -> accepted, and completes one cycle later.
- rst asserted at cycle 8 of DIV 0x0100/0x0002 -> busy=0 next cycle and no wr_en pulse within 20 cycles. A following ADD 0x0002+0x0003 -> 0x0005 correct.
